wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-cycle sequencer that computes a WIDTH-bit addition with a single LIMB-bit adder slice, one limb per clock, least-significant limb first. It carries the inter-limb carry in a register between cycles. It is the area-reduced alternative to the fully combinational 120-bit ripple adder, for datapath stages that tolerate latency. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 120: operand and result width in bits.
- LIMB, 16: bits added per cycle. NLIMB = ceil(WIDTH/LIMB), which is 8 at the defaults.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  sequencer can accept operands.
- a  input  WIDTH  operand A, sampled at acceptance.
- b  input  WIDTH  operand B, sampled at acceptance.
- carry_in  input  1  initial carry, used only with WIDE_ADD_CIN_EN.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- carry  output  1  registered carry out, equal to bit WIDTH of the true sum.
- busy  output  1  high in the RUN state.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, the block latches a, b and the initial carry, zero-extended to NLIMB*LIMB bits.
  - It clears the limb counter and goes to RUN.
- RUN:
  - Each cycle the block adds limb[idx] of A, limb[idx] of B and the carry register.
  - It writes the LIMB-bit result into sum limb idx and updates the carry register from bit LIMB of the slice sum.
  - The counter increments each cycle. On the cycle where idx = NLIMB-1, the next state is DONE.
- Final partial limb (WIDTH not a multiple of LIMB): the upper bits are zero-padded. carry is taken from bit WIDTH of the padded result, not from the slice carry. At the defaults, carry is bit 8 of the 8th-limb slice sum.
- DONE:
  - out_valid = 1. sum and carry are held stable.
  - When out_ready is high, the block goes to IDLE.
- in_valid is ignored outside IDLE. Operands are sampled only at acceptance and may change freely afterwards.
- Arithmetic is unsigned modulo 2^WIDTH, with the overflow bit on carry.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, in_ready = 1.
  - out_valid = 0, busy = 0.
  - sum = 0, carry = 0, counter = 0, carry register = 0.
- Reset mid-RUN or in DONE discards the operation. No result is ever presented for it.
- Acceptance edge T0: the edge where in_valid and in_ready are both high.
- Limb k is written at edge T0+1+k, for k = 0 to NLIMB-1.
- out_valid rises after edge T0+NLIMB. At the defaults this is 8 cycles after acceptance.
- busy is high for exactly NLIMB cycles per operation.
- Output handshake at edge T1: the block returns to IDLE after T1 and in_ready is 1 in the next cycle.
  - The next acceptance can happen no earlier than T1+1.
  - Minimum issue interval is NLIMB+2 cycles.
- No combinational path from any input to in_ready, out_valid or busy. All three are decoded from the state register only.
- sum and carry change only during RUN. During DONE they are stable regardless of out_ready.

## Configuration
- WIDE_ADD_CIN_EN defined: carry_in is latched at acceptance and seeds the carry register for limb 0.
- WIDE_ADD_CIN_EN undefined:
  - The carry register is seeded with 0.
  - carry_in is unused. It stays in the port list so the interface is identical in both builds.

## Test plan
- Full-width carry chain: a = 2^120-1, b = 1, carry_in = 0. Required: out_valid rises exactly 8 cycles after acceptance, sum = 0, carry = 1, busy high for 8 cycles.
- Limb boundary: a = 0x0000_FFFF, b = 0x0000_0001. Required: sum = 0x1_0000, carry = 0. Repeat with a = 0xFFFF_FFFF, b = 1. Required: sum = 0x1_0000_0000.
- Carry-in seed: a = 0, b = 0, carry_in = 1. Required with WIDE_ADD_CIN_EN: sum = 1, carry = 0. Required without the macro: sum = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid with new operands. Required: sum and carry stable, in_ready = 0, no new acceptance, in_ready = 1 one cycle after the out_ready handshake.
- Reset mid-operation: assert rst during RUN at limb 4. Required: all outputs return to their reset values immediately and no out_valid pulse follows. A new operation a = 5, b = 7 gives sum = 12.
- Random regression: 1000 random a/b/carry_in pairs issued back-to-back with random out_ready stalls. Each result must equal a + b + cin (cin = 0 without the macro), with sum = low 120 bits and carry = bit 120.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq: producer side (in_*, a, b, carry_in)
// and consumer side (out_*, sum, carry) plus the busy status.
interface wide_add_seq_if #(
    parameter int unsigned WIDTH = 120
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry, busy
    );

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry, busy
    );
endinterface

// File: rtl/wide_add_seq.sv
// Serial WIDTH-bit adder: one LIMB-bit slice per clock, LS limb first, carry kept in a register.
// Optional WIDE_ADD_CIN_EN: carry_in is latched at acceptance and seeds the limb-0 carry.
module wide_add_seq #(
    parameter int unsigned WIDTH = 120,
    parameter int unsigned LIMB  = 16
) (
    input logic           clk,
    input logic           rst,
    wide_add_seq_if.slave bus
);
    localparam int unsigned NLIMB = (WIDTH + LIMB - 1) / LIMB;
    localparam int unsigned PW    = NLIMB * LIMB;
    localparam int unsigned IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    // Position of true bit WIDTH inside the last (possibly partial) slice sum
    localparam int unsigned CBIT  = WIDTH - (NLIMB - 1) * LIMB;
    localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IW-1:0]    idx_q;
    logic             cy_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [LIMB-1:0]  a_limb;
    logic [LIMB-1:0]  b_limb;
    logic [LIMB:0]    slice;
    logic [WIDTH-1:0] sum_d;
    logic             cin_seed;

`ifdef WIDE_ADD_CIN_EN
    assign cin_seed = bus.carry_in;
`else
    assign cin_seed = 1'b0;
`endif

    // Single adder slice; padding bits beyond WIDTH are never stored in sum
    always_comb begin
        a_ext  = PW'(a_q);
        b_ext  = PW'(b_q);
        a_limb = a_ext[LIMB * 32'(idx_q) +: LIMB];
        b_limb = b_ext[LIMB * 32'(idx_q) +: LIMB];
        slice  = (LIMB + 1)'(a_limb) + (LIMB + 1)'(b_limb) + (LIMB + 1)'(cy_q);
        sum_d  = sum_q;
        for (int unsigned j = 0; j < LIMB; j++) begin
            if (LIMB * 32'(idx_q) + j < WIDTH) begin
                sum_d[LIMB * 32'(idx_q) + j] = slice[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        cy_q       <= cin_seed;
                        idx_q      <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q <= sum_d;
                    cy_q  <= slice[LIMB];
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        carry_q     <= slice[CBIT];
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: directed carry/limb/reset/backpressure cases plus
// 1000 random back-to-back operations with random output stalls.
module tb_wide_add_seq;
    localparam int unsigned WIDTH = 120;
    localparam int unsigned LIMB  = 16;
    localparam int unsigned NLIMB = (WIDTH + LIMB - 1) / LIMB;
`ifdef WIDE_ADD_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wide_add_seq_if #(.WIDTH(WIDTH)) bus ();

    wide_add_seq #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] sb_q[$];

    task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic cin);
        return {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(CIN_EN & cin);
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return WIDTH'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready)
                sb_q.push_back(model(bus.a, bus.b, bus.carry_in));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", (WIDTH + 1)'(sb_q.size()), 1);
                end else begin
                    check("sb_result", {bus.carry, bus.sum}, sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin,
                          input int stall, input string tag);
        logic [WIDTH:0] exp;
        int lat;
        int bc;
        int guard;
        exp          = model(x, y, cin);
        bus.a        = x;
        bus.b        = y;
        bus.carry_in = cin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_in_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.a        = rnd();
        bus.b        = rnd();
        bus.carry_in = ~cin;
        lat = 0;
        bc  = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) bc++;
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, NLIMB);
        check({tag, "_busy_cycles"}, bc, NLIMB);
        check({tag, "_busy_done"}, bus.busy, 0);
        check({tag, "_result"}, {bus.carry, bus.sum}, exp);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = rnd();
            bus.b        = rnd();
            step();
            check({tag, "_stall_result"}, {bus.carry, bus.sum}, exp);
            check({tag, "_stall_in_ready"}, bus.in_ready, 0);
            check({tag, "_stall_out_valid"}, bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check({tag, "_post_in_ready"}, bus.in_ready, 1);
        check({tag, "_post_out_valid"}, bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int seen;
        int guard;
        bit acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", {1'b0, bus.sum}, 0);
        check("rst_carry", bus.carry, 0);
        step();
        rst = 1'b0;
        step();

        run_op('1, 1, 1'b0, 5, "carry_chain");
        run_op(WIDTH'(32'h0000_FFFF), 1, 1'b0, 0, "limb16");
        run_op(WIDTH'(32'hFFFF_FFFF), 1, 1'b0, 1, "limb32");
        run_op(0, 0, 1'b1, 0, "cin_seed");

        // Reset while limb 4 is being added
        bus.a        = rnd();
        bus.b        = rnd();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sum", {1'b0, bus.sum}, 0);
        check("mid_rst_carry", bus.carry, 0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        run_op(5, 7, 1'b0, 2, "post_rst");

        // Random back-to-back regression with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            ra = rnd();
            rb = rnd();
            if (n % 8 == 0) ra = '1;
            bus.a        = ra;
            bus.b        = rb;
            bus.carry_in = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                acc = bus.in_ready;
                step();
                bus.out_ready = ($urandom_range(0, 3) != 0);
                guard++;
            end
            if (!acc) begin
                check("rand_accept", acc, 1);
                break;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        check("sb_drain", (WIDTH + 1)'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
